// File: rtl/wrp_unshff_sw.sv
// wrp_unshff_sw: inverse 16-lane diagonal shuffle (lane j <- lane (j+k) mod 16), 6-cycle pipeline.
// Define WRP_UNSHFF_SW_FRAME_ERR_EN to add the err_o framing-error pulse.
module wrp_unshff_sw #(
  parameter int BITWIDTH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                vld_i,
  input  logic [BITWIDTH-1:0] x00_i,
  input  logic [BITWIDTH-1:0] x01_i,
  input  logic [BITWIDTH-1:0] x02_i,
  input  logic [BITWIDTH-1:0] x03_i,
  input  logic [BITWIDTH-1:0] x04_i,
  input  logic [BITWIDTH-1:0] x05_i,
  input  logic [BITWIDTH-1:0] x06_i,
  input  logic [BITWIDTH-1:0] x07_i,
  input  logic [BITWIDTH-1:0] x10_i,
  input  logic [BITWIDTH-1:0] x11_i,
  input  logic [BITWIDTH-1:0] x12_i,
  input  logic [BITWIDTH-1:0] x13_i,
  input  logic [BITWIDTH-1:0] x14_i,
  input  logic [BITWIDTH-1:0] x15_i,
  input  logic [BITWIDTH-1:0] x16_i,
  input  logic [BITWIDTH-1:0] x17_i,
  output logic                vld_o,
  output logic                sof_o,
`ifdef WRP_UNSHFF_SW_FRAME_ERR_EN
  output logic                err_o,
`endif
  output logic [BITWIDTH-1:0] y00_o,
  output logic [BITWIDTH-1:0] y01_o,
  output logic [BITWIDTH-1:0] y02_o,
  output logic [BITWIDTH-1:0] y03_o,
  output logic [BITWIDTH-1:0] y04_o,
  output logic [BITWIDTH-1:0] y05_o,
  output logic [BITWIDTH-1:0] y06_o,
  output logic [BITWIDTH-1:0] y07_o,
  output logic [BITWIDTH-1:0] y10_o,
  output logic [BITWIDTH-1:0] y11_o,
  output logic [BITWIDTH-1:0] y12_o,
  output logic [BITWIDTH-1:0] y13_o,
  output logic [BITWIDTH-1:0] y14_o,
  output logic [BITWIDTH-1:0] y15_o,
  output logic [BITWIDTH-1:0] y16_o,
  output logic [BITWIDTH-1:0] y17_o
);

  typedef logic [15:0][BITWIDTH-1:0] lanes_t;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  // Lane j of the result takes lane (j+amt) mod 16 of the source.
  function automatic lanes_t rot_lanes(input lanes_t x, input logic [3:0] amt);
    lanes_t     y;
    logic [3:0] idx;
    for (int j = 0; j < 16; j++) begin
      idx  = amt + 4'(j);
      y[j] = x[idx];
    end
    return y;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_k;
  logic [3:0] w_k_nxt;
  logic       w_acc;
  logic       w_sof;
  logic [3:0] w_tag;
  lanes_t     w_x;

  lanes_t     r_d0, r_d1, r_d2, r_d3, r_d4, r_d5;
  logic [5:0] r_v;
  logic [5:0] r_sof;
  logic [3:0] r_k0;
  logic [2:0] r_k1;
  logic [1:0] r_k2;
  logic       r_k3;

  assign w_x = {x17_i, x16_i, x15_i, x14_i, x13_i, x12_i, x11_i, x10_i,
                x07_i, x06_i, x05_i, x04_i, x03_i, x02_i, x01_i, x00_i};

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_k     <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Next frame state: a start always restarts at beat 0; beat 15 closes the frame.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      ST_IDLE: begin
        if (vld_i && start_i) begin
          w_state_nxt = ST_ACTIVE;
          w_k_nxt     = 4'd1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (vld_i && start_i) begin
          w_k_nxt = 4'd1;
        end else if (vld_i) begin
          if (r_k == 4'd15) begin
            w_state_nxt = ST_IDLE;
            w_k_nxt     = 4'd0;
          end else begin
            w_k_nxt = r_k + 4'd1;
          end
        end else begin
          w_k_nxt = r_k;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_k_nxt     = 4'd0;
      end
    endcase
  end

  // Beat acceptance and tagging; stray beats in IDLE are dropped.
  always_comb begin
    w_acc = 1'b0;
    w_sof = 1'b0;
    w_tag = 4'd0;
    case (r_state)
      ST_IDLE: begin
        if (vld_i && start_i) begin
          w_acc = 1'b1;
          w_sof = 1'b1;
        end else begin
          w_acc = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (vld_i) begin
          w_acc = 1'b1;
          if (start_i) begin
            w_sof = 1'b1;
          end else begin
            w_tag = r_k;
          end
        end else begin
          w_acc = 1'b0;
        end
      end
      default: begin
        w_acc = 1'b0;
      end
    endcase
  end

  // Pipeline: input reg, rotate 8/4/2/1 keyed by k[3..0], output reg; data moves only with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
      r_d3  <= '0;
      r_d4  <= '0;
      r_d5  <= '0;
      r_v   <= 6'd0;
      r_sof <= 6'd0;
      r_k0  <= 4'd0;
      r_k1  <= 3'd0;
      r_k2  <= 2'd0;
      r_k3  <= 1'b0;
    end else begin
      r_v   <= {r_v[4:0], w_acc};
      r_sof <= {r_sof[4:0], w_sof & w_acc};
      r_k0  <= w_tag;
      r_k1  <= r_k0[2:0];
      r_k2  <= r_k1[1:0];
      r_k3  <= r_k2[0];
      r_d0  <= w_acc  ? w_x : r_d0;
      r_d1  <= r_v[0] ? (r_k0[3] ? rot_lanes(r_d0, 4'd8) : r_d0) : r_d1;
      r_d2  <= r_v[1] ? (r_k1[2] ? rot_lanes(r_d1, 4'd4) : r_d1) : r_d2;
      r_d3  <= r_v[2] ? (r_k2[1] ? rot_lanes(r_d2, 4'd2) : r_d2) : r_d3;
      r_d4  <= r_v[3] ? (r_k3    ? rot_lanes(r_d3, 4'd1) : r_d3) : r_d4;
      r_d5  <= r_v[4] ? r_d4 : r_d5;
    end
  end

`ifdef WRP_UNSHFF_SW_FRAME_ERR_EN
  logic       w_err;
  logic [5:0] r_err;

  // Framing error: restart while ACTIVE, or a non-start beat while IDLE.
  always_comb begin
    w_err = 1'b0;
    if (vld_i && start_i && (r_state == ST_ACTIVE)) begin
      w_err = 1'b1;
    end else if (vld_i && !start_i && (r_state == ST_IDLE)) begin
      w_err = 1'b1;
    end else begin
      w_err = 1'b0;
    end
  end

  // Error flag rides the pipeline so it lands with the offending beat slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 6'd0;
    end else begin
      r_err <= {r_err[4:0], w_err};
    end
  end

  assign err_o = r_err[5];
`endif

  assign vld_o = r_v[5];
  assign sof_o = r_sof[5];
  assign y00_o = r_d5[0];
  assign y01_o = r_d5[1];
  assign y02_o = r_d5[2];
  assign y03_o = r_d5[3];
  assign y04_o = r_d5[4];
  assign y05_o = r_d5[5];
  assign y06_o = r_d5[6];
  assign y07_o = r_d5[7];
  assign y10_o = r_d5[8];
  assign y11_o = r_d5[9];
  assign y12_o = r_d5[10];
  assign y13_o = r_d5[11];
  assign y14_o = r_d5[12];
  assign y15_o = r_d5[13];
  assign y16_o = r_d5[14];
  assign y17_o = r_d5[15];

endmodule

// File: tb/tb_wrp_unshff_sw.sv
// Bench for wrp_unshff_sw: table of beats with hand-written tags, scoreboard queue keyed on due cycle.
module tb_wrp_unshff_sw;
  localparam int W = 64;
  typedef logic [15:0][W-1:0] lanes_t;

  typedef struct {
    logic       s;
    logic       v;
    logic       acc;
    logic       sof;
    logic [3:0] tag;
    logic       err;
  } vec_t;

  typedef struct {
    int     due;
    logic   sof;
    lanes_t lanes;
  } sb_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start_i = 1'b0;
  logic   vld_i = 1'b0;
  lanes_t xin = '0;
  lanes_t yout;
  lanes_t last = '0;
  logic   vld_o, sof_o;
`ifdef WRP_UNSHFF_SW_FRAME_ERR_EN
  logic   err_o;
  int     errq[$];
`endif
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     err_marks = 0;
  sb_t    sbq[$];
  vec_t   tbl[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wrp_unshff_sw #(.BITWIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .vld_i(vld_i),
    .x00_i(xin[0]),  .x01_i(xin[1]),  .x02_i(xin[2]),  .x03_i(xin[3]),
    .x04_i(xin[4]),  .x05_i(xin[5]),  .x06_i(xin[6]),  .x07_i(xin[7]),
    .x10_i(xin[8]),  .x11_i(xin[9]),  .x12_i(xin[10]), .x13_i(xin[11]),
    .x14_i(xin[12]), .x15_i(xin[13]), .x16_i(xin[14]), .x17_i(xin[15]),
    .vld_o(vld_o), .sof_o(sof_o),
`ifdef WRP_UNSHFF_SW_FRAME_ERR_EN
    .err_o(err_o),
`endif
    .y00_o(yout[0]),  .y01_o(yout[1]),  .y02_o(yout[2]),  .y03_o(yout[3]),
    .y04_o(yout[4]),  .y05_o(yout[5]),  .y06_o(yout[6]),  .y07_o(yout[7]),
    .y10_o(yout[8]),  .y11_o(yout[9]),  .y12_o(yout[10]), .y13_o(yout[11]),
    .y14_o(yout[12]), .y15_o(yout[13]), .y16_o(yout[14]), .y17_o(yout[15])
  );

  // Output monitor: compares every cycle against the scoreboard head.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      last = '0;
    end else begin
      if (vld_o) begin
        checks++;
        if (sbq.size() == 0 || sbq[0].due != cyc) begin
          errors++;
          $display("FAIL unexpected_vld cyc=%0d got vld_o=1 want 0 (queued=%0d)", cyc, sbq.size());
          if (sbq.size() != 0 && sbq[0].due < cyc) void'(sbq.pop_front());
        end else begin
          e = sbq.pop_front();
          checks++;
          if (sof_o !== e.sof) begin
            errors++;
            $display("FAIL sof cyc=%0d got %b want %b", cyc, sof_o, e.sof);
          end
          checks++;
          if (yout !== e.lanes) begin
            errors++;
            $display("FAIL lanes cyc=%0d got %h want %h", cyc, yout, e.lanes);
          end
        end
      end else begin
        checks++;
        if (sof_o !== 1'b0 || (sbq.size() != 0 && sbq[0].due <= cyc)) begin
          errors++;
          $display("FAIL missing_vld cyc=%0d got vld_o=0 sof_o=%b want beat due=%0d", cyc, sof_o,
                   (sbq.size() != 0) ? sbq[0].due : -1);
          if (sbq.size() != 0 && sbq[0].due <= cyc) void'(sbq.pop_front());
        end
        checks++;
        if (yout !== last) begin
          errors++;
          $display("FAIL hold cyc=%0d got %h want %h", cyc, yout, last);
        end
      end
`ifdef WRP_UNSHFF_SW_FRAME_ERR_EN
      begin
        logic exp_err;
        exp_err = (errq.size() != 0 && errq[0] == cyc);
        if (exp_err) void'(errq.pop_front());
        checks++;
        if (err_o !== exp_err) begin
          errors++;
          $display("FAIL err cyc=%0d got %b want %b", cyc, err_o, exp_err);
        end
      end
`endif
      last = yout;
    end
  end

  task automatic drive(input logic s, input logic v, input lanes_t xv, input logic acc,
                       input logic sf, input lanes_t ev, input logic er);
    sb_t e;
    @(negedge clk);
    start_i = s;
    vld_i   = v;
    xin     = xv;
    if (acc) begin
      e.due   = cyc + 6;
      e.sof   = sf;
      e.lanes = ev;
      sbq.push_back(e);
    end
    if (er) err_marks++;
`ifdef WRP_UNSHFF_SW_FRAME_ERR_EN
    if (er) errq.push_back(cyc + 6);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic add(input logic s, input logic v, input logic acc, input logic sf,
                     input logic [3:0] tag, input logic er);
    vec_t t;
    t.s = s; t.v = v; t.acc = acc; t.sof = sf; t.tag = tag; t.err = er;
    tbl.push_back(t);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    lanes_t     xv, ev;
    logic [3:0] l;
    lanes_t     orig [16];

    // contiguous frame
    for (int k = 0; k < 16; k++) add(k == 0, 1'b1, 1'b1, k == 0, 4'(k), 1'b0);
    add_idle(8);
    // gapped frame
    for (int k = 0; k < 16; k++) begin
      add_idle(1);
      add(k == 0, 1'b1, 1'b1, k == 0, 4'(k), 1'b0);
    end
    add_idle(8);
    // restart at beat 9, then a full frame
    for (int k = 0; k < 9; k++) add(k == 0, 1'b1, 1'b1, k == 0, 4'(k), 1'b0);
    for (int k = 0; k < 16; k++) add(k == 0, 1'b1, 1'b1, k == 0, 4'(k), k == 0);
    add_idle(8);
    // stray beat in IDLE
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    add_idle(8);
    // start without valid is ignored, so the next beat is still stray
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    add_idle(8);

    // reset state
    #2;
    checks++;
    if (vld_o !== 1'b0 || sof_o !== 1'b0 || yout !== '0) begin
      errors++;
      $display("FAIL reset_state got vld=%b sof=%b y=%h want all 0", vld_o, sof_o, yout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int n = 0; n < tbl.size(); n++) begin
      for (int i = 0; i < 16; i++) begin
        l     = 4'(i) + tbl[n].tag;
        xv[i] = W'(n * 16 + i);
        ev[i] = W'(n * 16 + int'(l));
      end
      drive(tbl[n].s, tbl[n].v, xv, tbl[n].acc, tbl[n].sof, ev, tbl[n].err);
    end

    // reset during beat 5 of a frame: in-flight beats are discarded
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) xv[i] = W'(32'hA000 + k * 16 + i);
      drive(k == 0, 1'b1, xv, 1'b0, 1'b0, '0, 1'b0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    vld_i = 1'b0;
    start_i = 1'b0;
    sbq.delete();
`ifdef WRP_UNSHFF_SW_FRAME_ERR_EN
    errq.delete();
`endif
    #1;
    checks++;
    if (vld_o !== 1'b0 || sof_o !== 1'b0 || yout !== '0) begin
      errors++;
      $display("FAIL mid_reset got vld=%b sof=%b y=%h want all 0", vld_o, sof_o, yout);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(12);

    // round trip: forward shuffle (lane j <- lane (j-k)) then the DUT restores the original
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 16; i++) orig[k][i] = {$urandom(), $urandom()};
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) begin
        l     = 4'(j) - 4'(k);
        xv[j] = orig[k][l];
      end
      drive(k == 0, 1'b1, xv, 1'b1, k == 0, orig[k], 1'b0);
    end
    idle(12);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending beats want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
